tt_sweep_checker: RTL and testbench

Sequential stimulus/capture stage that sits directly upstream of a 7-input combinational classification network. It drives all 128 input minterms into the network, captures the network output into a 128-bit truth table and compares it against the expected function. It reports match, mismatch count, first mismatching minterm and ones count. It is the self-check harness used to qualify every synthesized 7-input network against its hex truth-table name.

---
 rtl/tt_sweep_checker.sv | 160 ++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_checker
// Description : Sweeps all 128 minterms into a 7-input network, captures its
//               truth table and compares it against EXPECTED.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_checker #(
    parameter logic [127:0] EXPECTED = 128'hfeeaeae8eeaae888eee8aa88e8a8a880,
    parameter int           LAT      = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         x0,
    output logic         x1,
    output logic         x2,
    output logic         x3,
    output logic         x4,
    output logic         x5,
    output logic         x6,
    input  logic         dut_out,
    output logic [127:0] truth_table,
    output logic         match,
    output logic [7:0]   mismatch_cnt,
    output logic [6:0]   first_mm,
    output logic         first_mm_valid,
    output logic [7:0]   ones_cnt
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_sweep = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;
    localparam logic [6:0] c_last     = 7'd127;

    logic [1:0]   r_state;
    logic [6:0]   r_x;
    logic [6:0]   r_sidx;
    logic [127:0] r_tt;
    logic [7:0]   r_mm_cnt;
    logic [7:0]   r_ones_cnt;
    logic [6:0]   r_first_mm;
    logic         r_first_mm_valid;
    logic         r_results_valid;

    logic w_start_acc;
    logic w_in_sweep;
    logic w_cap_valid;
    logic w_cap_last;
    logic w_mm;

    assign w_start_acc = start && (r_state == c_st_idle);
    assign w_in_sweep  = (r_state == c_st_sweep);

    // Sample strobe trails the presented vector by LAT edges.
    generate
        if (LAT == 0) begin : g_lat_zero
            assign w_cap_valid = w_in_sweep;
        end else begin : g_lat_pipe
            logic [LAT-1:0] r_pv;
            always_ff @(posedge clk) begin
                if (rst || w_start_acc) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_in_sweep;
                    for (int k = 1; k < LAT; k++) begin
                        r_pv[k] <= r_pv[k-1];
                    end
                end
            end
            assign w_cap_valid = r_pv[LAT-1];
        end
    endgenerate

    assign w_cap_last = w_cap_valid && (r_sidx == c_last);
    assign w_mm       = (dut_out != EXPECTED[r_sidx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_st_idle;
            r_x              <= '0;
            r_sidx           <= '0;
            r_tt             <= '0;
            r_mm_cnt         <= '0;
            r_ones_cnt       <= '0;
            r_first_mm       <= '0;
            r_first_mm_valid <= 1'b0;
            r_results_valid  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state          <= c_st_sweep;
                        r_x              <= '0;
                        r_sidx           <= '0;
                        r_tt             <= '0;
                        r_mm_cnt         <= '0;
                        r_ones_cnt       <= '0;
                        r_first_mm       <= '0;
                        r_first_mm_valid <= 1'b0;
                        r_results_valid  <= 1'b0;
                    end
                end
                c_st_sweep: begin
                    if (r_x == c_last) begin
                        if (w_cap_last) begin
                            r_state         <= c_st_done;
                            r_x             <= '0;
                            r_results_valid <= 1'b1;
                        end else begin
                            r_state <= c_st_drain;
                        end
                    end else begin
                        r_x <= r_x + 7'd1;
                    end
                end
                c_st_drain: begin
                    if (w_cap_last) begin
                        r_state         <= c_st_done;
                        r_x             <= '0;
                        r_results_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            if (w_cap_valid) begin
                r_tt[r_sidx] <= dut_out;
                r_sidx       <= r_sidx + 7'd1;
                if (w_mm) begin
                    r_mm_cnt <= r_mm_cnt + 8'd1;
                    if (!r_first_mm_valid) begin
                        r_first_mm       <= r_sidx;
                        r_first_mm_valid <= 1'b1;
                    end
                end
                if (dut_out) begin
                    r_ones_cnt <= r_ones_cnt + 8'd1;
                end
            end
        end
    end

    assign busy           = (r_state == c_st_sweep) || (r_state == c_st_drain);
    assign done           = (r_state == c_st_done);
    assign {x6, x5, x4, x3, x2, x1, x0} = r_x;
    assign truth_table    = r_tt;
    assign mismatch_cnt   = r_mm_cnt;
    assign ones_cnt       = r_ones_cnt;
    assign first_mm       = r_first_mm;
    assign first_mm_valid = r_first_mm_valid;
    assign match          = r_results_valid && (r_mm_cnt == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep_checker
// Description : Scoreboard bench for tt_sweep_checker at LAT=0 and LAT=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_checker;

    localparam logic [127:0] c_ref = 128'hfeeaeae8eeaae888eee8aa88e8a8a880;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, start0 = 1'b0, start2 = 1'b0;
    logic         dout0, dout2;
    logic         busy0, done0, busy2, done2;
    logic [6:0]   xa, xb;
    logic [127:0] tt0, tt2;
    logic         match0, match2, fmv0, fmv2;
    logic [7:0]   mm0, mm2, ones0, ones2;
    logic [6:0]   fm0, fm2;
    logic [127:0] ref_tt = c_ref;
    logic         d1a = 1'b0, d2a = 1'b0, d1b = 1'b0, d2b = 1'b0;
    int           mode0 = 0;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   mm;
        logic [6:0]   fm;
        logic         fmv;
        logic [7:0]   ones;
        logic         m;
        int           lat;
    } exp_t;
    exp_t sb[$];

    tt_sweep_checker #(.EXPECTED(c_ref), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .x4(xa[4]), .x5(xa[5]), .x6(xa[6]),
        .dut_out(dout0), .truth_table(tt0), .match(match0), .mismatch_cnt(mm0),
        .first_mm(fm0), .first_mm_valid(fmv0), .ones_cnt(ones0)
    );

    tt_sweep_checker #(.EXPECTED(c_ref), .LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .x4(xb[4]), .x5(xb[5]), .x6(xb[6]),
        .dut_out(dout2), .truth_table(tt2), .match(match2), .mismatch_cnt(mm2),
        .first_mm(fm2), .first_mm_valid(fmv2), .ones_cnt(ones2)
    );

    // Reference network, optionally followed by two registers
    always @(posedge clk) begin
        d1a <= ref_tt[xa];
        d2a <= d1a;
        d1b <= ref_tt[xb];
        d2b <= d1b;
    end

    always_comb begin
        dout0 = 1'b0;
        case (mode0)
            0:       dout0 = ref_tt[xa];
            2:       dout0 = d2a;
            default: dout0 = 1'b0;
        endcase
    end
    assign dout2 = d2b;

    function automatic exp_t ref_exp(input int lat);
        exp_t e;
        e.tt = ref_tt; e.mm = 8'd0; e.fm = 7'd0; e.fmv = 1'b0;
        e.ones = 8'd64; e.m = 1'b1; e.lat = 128 + lat;
        return e;
    endfunction

    function automatic exp_t model_exp(input logic [127:0] tt, input int lat);
        exp_t e;
        logic [127:0] diff;
        diff   = tt ^ ref_tt;
        e.tt   = tt;
        e.mm   = 8'($countones(diff));
        e.ones = 8'($countones(tt));
        e.fmv  = |diff;
        e.fm   = 7'd0;
        for (int i = 127; i >= 0; i--) if (diff[i]) e.fm = 7'(i);
        e.m    = (diff == 128'd0);
        e.lat  = 128 + lat;
        return e;
    endfunction

    task automatic run_sweep(input int inst, input bit check_x);
        exp_t e;
        int k;
        bit seen;
        logic [6:0] xv;
        logic [127:0] att;
        logic [7:0] amm, aones;
        logic [6:0] afm;
        logic afmv, am, abusy, adone;
        e = sb.pop_front();
        repeat (3) @(negedge clk);
        if (inst == 0) start0 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 400) begin
            xv    = (inst == 0) ? xa : xb;
            adone = (inst == 0) ? done0 : done2;
            if (adone) begin
                seen = 1'b1;
            end else begin
                if (check_x) begin
                    checks++;
                    if (k < 128 && xv !== 7'(k)) begin
                        errors++; $display("FAIL x_seq[%0d]: got %0d expected %0d", k, xv, k);
                    end else if (k >= 128 && xv !== 7'd127) begin
                        errors++; $display("FAIL x_drain[%0d]: got %0d expected 127", k, xv);
                    end
                end
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL done_timeout: got no done expected done at %0d", e.lat);
        end else begin
            att   = (inst == 0) ? tt0 : tt2;
            amm   = (inst == 0) ? mm0 : mm2;
            aones = (inst == 0) ? ones0 : ones2;
            afm   = (inst == 0) ? fm0 : fm2;
            afmv  = (inst == 0) ? fmv0 : fmv2;
            am    = (inst == 0) ? match0 : match2;
            abusy = (inst == 0) ? busy0 : busy2;
            if (k !== e.lat) begin errors++; $display("FAIL latency: got %0d expected %0d", k, e.lat); end
            checks++;
            if (abusy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", abusy); end
            checks++;
            if (att !== e.tt) begin errors++; $display("FAIL truth_table: got %h expected %h", att, e.tt); end
            checks++;
            if (amm !== e.mm) begin errors++; $display("FAIL mismatch_cnt: got %0d expected %0d", amm, e.mm); end
            checks++;
            if (aones !== e.ones) begin errors++; $display("FAIL ones_cnt: got %0d expected %0d", aones, e.ones); end
            checks++;
            if (afmv !== e.fmv || afm !== e.fm) begin
                errors++; $display("FAIL first_mm: got %b/%0d expected %b/%0d", afmv, afm, e.fmv, e.fm);
            end
            checks++;
            if (am !== e.m) begin errors++; $display("FAIL match: got %b expected %b", am, e.m); end
            @(negedge clk);
            adone = (inst == 0) ? done0 : done2;
            checks++;
            if (adone !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", adone); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, xa, tt0, mm0, fm0, fmv0, ones0, match0} !== '0) begin
            errors++; $display("FAIL reset_lat0: got nonzero outputs tt=%h mm=%0d expected all 0", tt0, mm0);
        end
        checks++;
        if ({busy2, done2, xb, tt2, mm2, fm2, fmv2, ones2, match2} !== '0) begin
            errors++; $display("FAIL reset_lat2: got nonzero outputs tt=%h mm=%0d expected all 0", tt2, mm2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rst_with_start();
        rst = 1'b1; start0 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_beats_start: got busy %b expected 0", busy0); end
        @(negedge clk);
    endtask

    task automatic test_ref_lat0();
        mode0 = 0;
        sb.push_back(ref_exp(0));
        run_sweep(0, 1'b1);
    endtask

    task automatic test_tied0();
        exp_t e;
        mode0 = 1;
        e.tt = 128'd0; e.mm = 8'd64; e.fm = 7'd7; e.fmv = 1'b1;
        e.ones = 8'd0; e.m = 1'b0; e.lat = 128;
        sb.push_back(e);
        run_sweep(0, 1'b0);
        mode0 = 0;
    endtask

    task automatic test_lat2();
        sb.push_back(ref_exp(2));
        run_sweep(2, 1'b1);
    endtask

    task automatic test_delayed_lat0();
        logic [127:0] t;
        mode0 = 2;
        for (int i = 0; i < 128; i++) t[i] = (i < 2) ? ref_tt[0] : ref_tt[i-2];
        sb.push_back(model_exp(t, 0));
        run_sweep(0, 1'b0);
        mode0 = 0;
    endtask

    task automatic test_rst_mid();
        int dn;
        mode0 = 0;
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (xa !== 7'd50 || busy0 !== 1'b1) begin
            errors++; $display("FAIL mid_sweep_x: got x=%0d busy=%b expected x=50 busy=1", xa, busy0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy0, done0, xa, tt0, mm0, fm0, fmv0, ones0, match0} !== '0) begin
            errors++; $display("FAIL rst_mid: got tt=%h ones=%0d busy=%b x=%0d expected all 0", tt0, ones0, busy0, xa);
        end
        dn = 0;
        repeat (200) begin @(negedge clk); if (done0) dn++; end
        checks++;
        if (dn != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", dn); end
    endtask

    task automatic test_start_held();
        int dn, cyc, extra;
        exp_t e;
        logic [6:0] xq[$];
        mode0 = 0;
        sb.push_back(ref_exp(0));
        sb.push_back(ref_exp(0));
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        dn = 0; cyc = 0;
        while (dn < 2 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (busy0) xq.push_back(xa);
            if (done0) begin
                dn++;
                e = sb.pop_front();
                checks++;
                if (tt0 !== e.tt || mm0 !== e.mm || ones0 !== e.ones || match0 !== e.m) begin
                    errors++;
                    $display("FAIL held_result[%0d]: got tt=%h mm=%0d ones=%0d match=%b expected tt=%h mm=%0d ones=%0d match=%b",
                             dn, tt0, mm0, ones0, match0, e.tt, e.mm, e.ones, e.m);
                end
                if (dn == 2) start0 = 1'b0;
            end
        end
        start0 = 1'b0;
        checks++;
        if (dn != 2) begin errors++; $display("FAIL held_sweeps: got %0d done pulses expected 2", dn); end
        extra = 0;
        repeat (200) begin @(negedge clk); if (done0 || busy0) extra++; end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL held_extra: got %0d active cycles expected 0", extra); end
        checks++;
        if (xq.size() != 256) begin
            errors++; $display("FAIL held_x_count: got %0d expected 256", xq.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                if (xq[i] !== 7'(i % 128)) begin
                    errors++; $display("FAIL held_x_seq[%0d]: got %0d expected %0d", i, xq[i], i % 128);
                    break;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rst_with_start();
        test_ref_lat0();
        test_tied0();
        test_lat2();
        test_delayed_lat0();
        test_rst_mid();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
